// File: rtl/flash_loader_pkg.sv
// Constants shared by the flash and SD loader blocks: SPI flash opcodes,
// the dummy byte clocked out during reads, and the loader state encoding.
package flash_loader_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] SPI_DUMMY      = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAITX  = 3'd2,
        ST_MEMWR  = 3'd3,
        ST_FINISH = 3'd4
    } ldr_state_e;

    // Header byte sent for a given index: opcode, then the address MSB first.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] addr);
        case (idx)
            2'd0:    hdr_byte = FLASH_CMD_READ;
            2'd1:    hdr_byte = addr[23:16];
            2'd2:    hdr_byte = addr[15:8];
            default: hdr_byte = addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_loader.sv
// Copies len bytes from SPI flash (READ 0x03) into SRAM. It drives a shared SPI
// engine through strobe/tx and writes bytes one at a time over a req/ack port.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int MEM_AW = 19,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [23:0]       flash_addr,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              spi_own,
    output logic              flash_cs_n,
    output logic              spi_strobe,
    output logic [7:0]        spi_tx,
    input  logic              spi_busy,
    input  logic [7:0]        spi_rx,
    output logic [MEM_AW-1:0] mem_a,
    output logic [7:0]        mem_d,
    output logic              mem_we,
    input  logic              mem_ack
);

    ldr_state_e        state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [1:0]        idx_q, idx_d;
    logic              data_ph_q, data_ph_d;
    logic              first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              own_q, own_d;
    logic              cs_n_q, cs_n_d;
    logic              strobe_q, strobe_d;
    logic [7:0]        tx_q, tx_d;
    logic [MEM_AW-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_d_q, mem_d_d;
    logic              we_q, we_d;

    // Outputs are registered: strobe/tx are loaded on entry to SEND so the
    // strobe is high exactly during the single SEND cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        idx_d     = idx_q;
        data_ph_d = data_ph_q;
        first_d   = first_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        own_d     = own_q;
        cs_n_d    = cs_n_q;
        strobe_d  = 1'b0;
        tx_d      = tx_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        we_d      = we_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d    = flash_addr;
                        mem_a_d   = mem_base;
                        remain_d  = len;
                        idx_d     = 2'd0;
                        data_ph_d = 1'b0;
                        cs_n_d    = 1'b0;
                        busy_d    = 1'b1;
                        own_d     = 1'b1;
                        strobe_d  = 1'b1;
                        tx_d      = hdr_byte(2'd0, flash_addr);
                        state_d   = ST_SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                first_d = 1'b1;
                state_d = ST_WAITX;
            end
            ST_WAITX: begin
                // The engine raises busy one cycle after the strobe, so the
                // first WAITX cycle must not mistake idle for completion.
                first_d = 1'b0;
                if (!first_q && !spi_busy) begin
                    if (data_ph_q) begin
                        mem_d_d = spi_rx;
                        we_d    = 1'b1;
                        state_d = ST_MEMWR;
                    end else if (idx_q == 2'd3) begin
                        data_ph_d = 1'b1;
                        strobe_d  = 1'b1;
                        tx_d      = SPI_DUMMY;
                        state_d   = ST_SEND;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        strobe_d = 1'b1;
                        tx_d     = hdr_byte(idx_q + 2'd1, addr_q);
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_MEMWR: begin
                if (mem_ack) begin
                    we_d     = 1'b0;
                    mem_a_d  = mem_a_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        strobe_d = 1'b1;
                        tx_d     = SPI_DUMMY;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                own_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            cs_n_d   = 1'b1;
            we_d     = 1'b0;
            busy_d   = 1'b0;
            own_d    = 1'b0;
            done_d   = 1'b0;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            idx_q     <= '0;
            data_ph_q <= 1'b0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            own_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            strobe_q  <= 1'b0;
            tx_q      <= SPI_DUMMY;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            idx_q     <= idx_d;
            data_ph_q <= data_ph_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            own_q     <= own_d;
            cs_n_q    <= cs_n_d;
            strobe_q  <= strobe_d;
            tx_q      <= tx_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            we_q      <= we_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign spi_own    = own_q;
    assign flash_cs_n = cs_n_q;
    assign spi_strobe = strobe_q;
    assign spi_tx     = tx_q;
    assign mem_a      = mem_a_q;
    assign mem_d      = mem_d_q;
    assign mem_we     = we_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with SPI-engine and SRAM models; expected
// SPI bytes and memory writes are queued at stimulus time and checked on output.
module tb_flash_loader;

    localparam int MEM_AW = 19;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [23:0]       flash_addr = '0;
    logic [MEM_AW-1:0] mem_base = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy, done, spi_own, flash_cs_n, spi_strobe, mem_we;
    logic [7:0]        spi_tx, mem_d;
    logic [MEM_AW-1:0] mem_a;
    logic              spi_busy, mem_ack;
    logic [7:0]        spi_rx;

    int total = 0;
    int bad   = 0;

    logic [7:0]          tx_exp[$];
    logic [MEM_AW+7:0]   wr_exp[$];
    logic [7:0]          rx_q[$];

    int strobe_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int we_cycles = 0, last_we_cycles = 0;
    bit cs_low_seen = 0;
    int ack_delay = 0;

    flash_loader #(.MEM_AW(MEM_AW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .flash_addr(flash_addr), .mem_base(mem_base), .len(len),
        .busy(busy), .done(done), .spi_own(spi_own), .flash_cs_n(flash_cs_n),
        .spi_strobe(spi_strobe), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_rx(spi_rx),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI engine model: busy for 3 cycles after a strobe; data-phase
    // transfers (5th onward since CS fell) return the next queued rx byte.
    int spi_cnt = 0, xfer_no = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_busy <= 1'b0; spi_rx <= 8'h00; spi_cnt = 0; xfer_no = 0;
        end else begin
            if (flash_cs_n) xfer_no = 0;
            if (spi_strobe) begin
                spi_busy <= 1'b1; spi_cnt = 3; xfer_no++;
            end else if (spi_cnt != 0) begin
                spi_cnt--;
                if (spi_cnt == 0) begin
                    spi_busy <= 1'b0;
                    spi_rx <= (xfer_no > 4 && rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                end
            end
        end
    end

    // SRAM model: ack one cycle after ack_delay cycles of waiting.
    int ack_wait = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack <= 1'b0; ack_wait = 0;
        end else if (mem_we && !mem_ack) begin
            if (ack_wait >= ack_delay) begin mem_ack <= 1'b1; ack_wait = 0; end
            else ack_wait++;
        end else mem_ack <= 1'b0;
    end

    // Output monitor / scoreboard
    logic              prev_strobe = 0, prev_we = 0, prev_ack = 0;
    logic [MEM_AW-1:0] prev_a = '0;
    logic [7:0]        prev_d = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_strobe) begin
                strobe_cnt++;
                chk("strobe_one_cycle", prev_strobe, 1'b0);
                chk("strobe_expected", tx_exp.size() != 0, 1'b1);
                if (tx_exp.size() != 0) chk("spi_tx", spi_tx, tx_exp.pop_front());
            end
            if (mem_we) begin
                we_cycles++;
                if (prev_we && !prev_ack) begin
                    chk("mem_a_stable", mem_a, prev_a);
                    chk("mem_d_stable", mem_d, prev_d);
                end
                if (mem_ack) begin
                    logic [MEM_AW+7:0] w;
                    wr_cnt++;
                    last_we_cycles = we_cycles;
                    we_cycles = 0;
                    chk("write_expected", wr_exp.size() != 0, 1'b1);
                    if (wr_exp.size() != 0) begin
                        w = wr_exp.pop_front();
                        chk("mem_a", mem_a, w[MEM_AW+7:8]);
                        chk("mem_d", mem_d, w[7:0]);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("cs_high_at_done", flash_cs_n, 1'b1);
            end
            if (!flash_cs_n) cs_low_seen = 1;
            prev_strobe = spi_strobe; prev_we = mem_we; prev_ack = mem_ack;
            prev_a = mem_a; prev_d = mem_d;
        end else begin
            prev_strobe = 0; prev_we = 0; prev_ack = 0; we_cycles = 0;
        end
    end

    task automatic push_load2(input logic [23:0] fa, input logic [MEM_AW-1:0] mb,
                              input logic [7:0] d0, input logic [7:0] d1);
        tx_exp.push_back(8'h03);
        tx_exp.push_back(fa[23:16]);
        tx_exp.push_back(fa[15:8]);
        tx_exp.push_back(fa[7:0]);
        tx_exp.push_back(8'hFF);
        tx_exp.push_back(8'hFF);
        rx_q.push_back(d0);
        rx_q.push_back(d1);
        wr_exp.push_back({mb, d0});
        wr_exp.push_back({mb + 1'b1, d1});
    endtask

    task automatic start_load(input logic [23:0] fa, input logic [MEM_AW-1:0] mb,
                              input logic [LEN_W-1:0] n, input logic ab);
        @(negedge clk);
        flash_addr = fa; mem_base = mb; len = n; start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  n = 0;
        bit  got = 0;
        while (n < budget && !got) begin
            if (done) got = 1;
            else begin @(negedge clk); n++; end
        end
        chk("done_seen", got, 1'b1);
    endtask

    initial begin
        int d0, s0, w0, n;
        // Reset values
        #12;
        chk("rst_cs_n", flash_cs_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_own", spi_own, 1'b0);
        chk("rst_strobe", spi_strobe, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_tx", spi_tx, 8'hFF);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_d", mem_d, 0);
        @(negedge clk); rst_n = 1'b1;

        // Header scenario
        push_load2(24'h012345, 19'h01000, 8'hA5, 8'h5A);
        start_load(24'h012345, 19'h01000, 16'd2, 1'b0);
        chk("busy_after_start", busy, 1'b1);
        chk("own_after_start", spi_own, 1'b1);
        wait_done(300);
        chk("busy_during_done", busy, 1'b1);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("own_after_done", spi_own, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("cs_after_done", flash_cs_n, 1'b1);
        repeat (5) @(negedge clk);
        chk("hdr_done_count", done_cnt, 1);
        chk("hdr_tx_left", tx_exp.size(), 0);
        chk("hdr_wr_left", wr_exp.size(), 0);

        // Zero length
        cs_low_seen = 0; s0 = strobe_cnt; d0 = done_cnt;
        start_load(24'hABCDEF, 19'h00010, 16'd0, 1'b0);
        chk("zero_done_next", done, 1'b1);
        @(negedge clk);
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        chk("zero_cs_never_low", cs_low_seen, 1'b0);
        chk("zero_no_strobe", strobe_cnt, s0);
        chk("zero_done_count", done_cnt, d0 + 1);

        // Address wrap, plus a start while busy that must be ignored
        push_load2(24'hFEDCBA, 19'h7FFFF, 8'h11, 8'h22);
        start_load(24'hFEDCBA, 19'h7FFFF, 16'd2, 1'b0);
        repeat (3) @(negedge clk);
        start_load(24'h000111, 19'h00200, 16'd5, 1'b0);
        wait_done(300);
        repeat (3) @(negedge clk);
        chk("wrap_tx_left", tx_exp.size(), 0);
        chk("wrap_wr_left", wr_exp.size(), 0);

        // Slow memory; start+abort together in IDLE counts as start
        ack_delay = 5;
        push_load2(24'h100000, 19'h00400, 8'h3C, 8'hC3);
        start_load(24'h100000, 19'h00400, 16'd2, 1'b1);
        wait_done(400);
        chk("slow_we_cycles", last_we_cycles, 7);
        repeat (3) @(negedge clk);
        chk("slow_tx_left", tx_exp.size(), 0);
        chk("slow_wr_left", wr_exp.size(), 0);
        ack_delay = 0;

        // Abort during the second header byte
        d0 = done_cnt;
        tx_exp.push_back(8'h03);
        tx_exp.push_back(8'h77);
        start_load(24'h778899, 19'h00800, 16'd3, 1'b0);
        n = 0; s0 = 0;
        while (s0 < 2 && n < 50) begin
            if (spi_strobe) s0++;
            if (s0 < 2) begin @(negedge clk); n++; end
        end
        chk("abort_saw_hdr2", s0, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_cs_n", flash_cs_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_own", spi_own, 1'b0);
        chk("abort_we", mem_we, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_tx_left", tx_exp.size(), 0);
        push_load2(24'h0A0B0C, 19'h00900, 8'h66, 8'h99);
        start_load(24'h0A0B0C, 19'h00900, 16'd2, 1'b0);
        wait_done(300);
        repeat (3) @(negedge clk);
        chk("post_abort_wr_left", wr_exp.size(), 0);

        // Asynchronous reset during MEMWR
        ack_delay = 8;
        push_load2(24'h222222, 19'h00A00, 8'h12, 8'h34);
        start_load(24'h222222, 19'h00A00, 16'd2, 1'b0);
        n = 0;
        while (!mem_we && n < 100) begin @(negedge clk); n++; end
        chk("reached_memwr", mem_we, 1'b1);
        w0 = wr_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", mem_we, 1'b0);
        chk("arst_cs_n", flash_cs_n, 1'b1);
        chk("arst_busy", busy, 1'b0);
        tx_exp.delete(); wr_exp.delete(); rx_q.delete();
        repeat (3) @(negedge clk);
        chk("arst_no_write", wr_cnt, w0);
        rst_n = 1'b1;
        ack_delay = 0;
        push_load2(24'h333333, 19'h00B00, 8'h56, 8'h78);
        start_load(24'h333333, 19'h00B00, 16'd2, 1'b0);
        wait_done(300);
        repeat (3) @(negedge clk);
        chk("restart_tx_left", tx_exp.size(), 0);
        chk("restart_wr_left", wr_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter MEM_AW, default 19, meaning width of the SRAM byte address.
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the byte-count input.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-004 Ports, in order:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle request to load.
- abort  in  1  one-cycle cancel.
- flash_addr  in  24  flash source address.
- mem_base  in  MEM_AW  SRAM destination.
- len  in  LEN_W  byte count.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- spi_own  out  1  controller owns the SPI engine.
- flash_cs_n  out  1  flash chip select.
- spi_strobe  out  1  one-cycle start of an 8-bit SPI transfer.
- spi_tx  out  8  byte to shift out.
- spi_busy  in  1  engine transfer in progress.
- spi_rx  in  8  last received byte.
- mem_a  out  MEM_AW  write address.
- mem_d  out  8  write data.
- mem_we  out  1  write request.
- mem_ack  in  1  write accepted.

Function
REQ-005 States SHALL be IDLE, SEND, WAITX, MEMWR, FINISH.
REQ-006 IDLE, start=1, len!=0: latch flash_addr, mem_base and len; flash_cs_n<=0; busy<=1; spi_own<=1; header index<=0; go SEND.
REQ-007 IDLE, start=1, len==0: done=1 on the next cycle; no CS or SPI activity; stay IDLE.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 SEND: spi_strobe=1 for exactly one cycle, with spi_tx set as follows:
- 0x03, then A[23:16], A[15:8], A[7:0] for header indices 0..3.
- 0xFF during the data phase.
- Next state is WAITX.
REQ-010 WAITX: the first cycle SHALL ignore spi_busy; the state then waits until spi_busy=0.
REQ-011 WAITX exit, header index<3: increment the index and go SEND.
REQ-012 WAITX exit, header index==3: go SEND (first 0xFF dummy) and enter the data phase.
REQ-013 WAITX exit, data phase: capture spi_rx into mem_d and go MEMWR.
REQ-014 MEMWR: mem_we=1 with mem_a stable and mem_d stable until the cycle mem_ack=1.
- On the ack: mem_we=0, mem_a increments, remaining count decrements.
- If remaining reaches 0, go FINISH; otherwise go SEND.
REQ-015 mem_a SHALL wrap modulo 2^MEM_AW.
REQ-016 FINISH: flash_cs_n=1 and done=1 for one cycle; busy=0 and spi_own=0 on the following cycle; return to IDLE.
REQ-017 abort=1 in any non-IDLE state: the next cycle is IDLE with flash_cs_n=1, mem_we=0, busy=0, spi_own=0 and done=0.
- abort takes priority over every other transition.
- abort in IDLE has no effect.
REQ-018 A simultaneous start and abort in IDLE SHALL be treated as start.
REQ-019 mem_ack SHALL be ignored outside MEMWR.
REQ-020 spi_busy SHALL be ignored in IDLE, SEND and MEMWR.
REQ-021 Minimum latency from start to done SHALL be 4 header transfers plus len×(transfer + write) plus 2 cycles.

Reset
REQ-022 While rst_n=0, outputs SHALL be:
- state=IDLE.
- flash_cs_n=1.
- busy, done, spi_own, spi_strobe, mem_we = 0.
- spi_tx=0xFF.
- mem_a=0, mem_d=0.
REQ-023 Reset asserted mid-load SHALL release flash_cs_n immediately, asynchronously, with no further memory write.

Structure
REQ-024 The read opcode 0x03, the dummy byte 0xFF and the state encodings SHALL live in a shared constants include used by the flash and SD blocks.
REQ-025 flash_loader SHALL contain no sub-module.
- The existing SPI engine is instantiated at top level.
- Top level muxes the engine strobe/data and flash CS between the CPU path and this block, using spi_own.

Verification
REQ-026 Header scenario: flash_addr=0x012345, len=2, spi_rx model returning 0xA5 then 0x5A → spi_tx sequence 03,01,23,45,FF,FF; writes mem_base→0xA5 and mem_base+1→0x5A; done once; flash_cs_n high after done.
REQ-027 Zero length: start with len=0 → done exactly 1 cycle later; flash_cs_n never low; spi_strobe never high.
REQ-028 Wrap: mem_base=2^MEM_AW−1, len=2 → writes land at 2^MEM_AW−1 then 0.
REQ-029 Slow memory: mem_ack delayed 5 cycles → mem_we, mem_a and mem_d held stable for those 5 cycles; no extra strobe issued.
REQ-030 Abort during the second header byte → next cycle flash_cs_n=1, busy=0, done never asserted; a new start then completes normally.
REQ-031 Reset: rst_n pulled low during MEMWR → mem_we=0 and flash_cs_n=1 without a clock edge; a restart after reset completes normally.
